// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request/result bundle for the iterative multiply/divide unit
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative shift-add multiplier / restoring divider with HI/LO results
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic             r_sign_a;
    logic             r_sign_ab;
    logic             r_bzero;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_wh;
    logic [WIDTH-1:0] r_wl;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;

    logic             w_accept;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_add_a;
    logic [WIDTH:0]   w_add_b;
    logic [WIDTH+1:0] w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;
    logic             w_fix_dbz;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_sa     = bus.op[0] && bus.a[WIDTH-1];
    assign w_sb     = bus.op[0] && bus.b[WIDTH-1];
    assign w_abs_a  = w_sa ? -bus.a : bus.a;
    assign w_abs_b  = w_sb ? -bus.b : bus.b;

    // One shared adder: subtract for the divide trial, add for the multiply accumulate.
    assign w_rem_sh = {r_wh, r_wl[WIDTH-1]};
    assign w_add_a  = r_div ? w_rem_sh : {1'b0, r_wh};
    assign w_add_b  = (r_div || r_wl[0]) ? {1'b0, r_opb} : '0;
    assign w_sum    = r_div ? ({1'b0, w_add_a} - {1'b0, w_add_b})
                            : ({1'b0, w_add_a} + {1'b0, w_add_b});
    assign w_prod   = {r_wh, r_wl};

    always_comb begin
        w_fix_hi  = r_wh;
        w_fix_lo  = r_wl;
        w_fix_dbz = 1'b0;
        if (!r_div) begin
            {w_fix_hi, w_fix_lo} = r_sign_ab ? -w_prod : w_prod;
        end else if (r_bzero) begin
            w_fix_hi  = r_a_raw;
            w_fix_lo  = '1;
            w_fix_dbz = 1'b1;
        end else begin
            w_fix_hi = r_sign_a  ? -r_wh : r_wh;
            w_fix_lo = r_sign_ab ? -r_wl : r_wl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIXUP;
            S_FIXUP: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_sign_a  <= 1'b0;
            r_sign_ab <= 1'b0;
            r_bzero   <= 1'b0;
            r_a_raw   <= '0;
            r_opb     <= '0;
            r_wh      <= '0;
            r_wl      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dbz     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt     <= '0;
                r_div     <= bus.op[1];
                r_sign_a  <= w_sa;
                r_sign_ab <= w_sa ^ w_sb;
                r_bzero   <= (bus.b == '0);
                r_a_raw   <= bus.a;
                r_wh      <= '0;
                // Multiply: r_opb = multiplicand, r_wl = multiplier. Divide: r_opb = divisor, r_wl = dividend.
                r_opb     <= bus.op[1] ? w_abs_b : w_abs_a;
                r_wl      <= bus.op[1] ? w_abs_a : w_abs_b;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_div) begin
                    if (!w_sum[WIDTH+1]) begin
                        r_wh <= w_sum[WIDTH-1:0];
                        r_wl <= {r_wl[WIDTH-2:0], 1'b1};
                    end else begin
                        r_wh <= w_rem_sh[WIDTH-1:0];
                        r_wl <= {r_wl[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    r_wh <= w_sum[WIDTH:1];
                    r_wl <= {w_sum[0], r_wl[WIDTH-1:1]};
                end
            end else if (r_state == S_FIXUP) begin
                r_hi  <= w_fix_hi;
                r_lo  <= w_fix_lo;
                r_dbz <= w_fix_dbz;
            end
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.div_by_zero = r_dbz;
endmodule
